// File: rtl/nabp_seq_pkg.sv
// Shared state encoding and default sizing for the NABP projection-angle sequencer.
package nabp_seq_pkg;

  localparam int SEQ_ANGLE_W   = 8;
  localparam int SEQ_ANGLE_MAX = 180;
  localparam int SEQ_CNT_W     = 8;
  localparam int STALL_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_LOADING,
    S_PEND,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/nabp_angle_accu.sv
// Registered modulo-ANGLE_MAX angle accumulator: load captures start angle and step,
// advance adds the step and wraps below ANGLE_MAX.
module nabp_angle_accu
  import nabp_seq_pkg::*;
#(
  parameter int ANGLE_W   = SEQ_ANGLE_W,
  parameter int ANGLE_MAX = SEQ_ANGLE_MAX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [ANGLE_W-1:0] load_angle,
  input  logic [ANGLE_W-1:0] load_step,
  input  logic               advance,
  output logic [ANGLE_W-1:0] angle
);

  localparam logic [ANGLE_W:0] MAX_EXT = ANGLE_MAX[ANGLE_W:0];

  logic [ANGLE_W-1:0] step;
  logic [ANGLE_W:0]   sum;
  logic [ANGLE_W-1:0] next_angle;

  // One extra bit keeps the carry so a single subtract is enough (step < ANGLE_MAX).
  always_comb begin
    sum        = {1'b0, angle} + {1'b0, step};
    next_angle = sum[ANGLE_W-1:0];
    if (sum >= MAX_EXT) begin
      next_angle = ANGLE_W'(sum - MAX_EXT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      angle <= '0;
      step  <= '0;
    end else if (load) begin
      angle <= load_angle;
      step  <= load_step;
    end else if (advance) begin
      angle <= next_angle;
    end
  end

endmodule

// File: rtl/nabp_angle_sequencer.sv
// Projection-angle sequencer: prefetches each angle into the idle ping-pong buffer and grants it
// to swap control. Define NABP_SEQ_PERF_EN to add the stall_cycles counter port.
module nabp_angle_sequencer
  import nabp_seq_pkg::*;
#(
  parameter int ANGLE_W   = SEQ_ANGLE_W,
  parameter int ANGLE_MAX = SEQ_ANGLE_MAX,
  parameter int CNT_W     = SEQ_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ANGLE_W-1:0] cfg_angle_start,
  input  logic [ANGLE_W-1:0] cfg_angle_step,
  input  logic [CNT_W-1:0]   cfg_num_angles,
  output logic               ld_kick,
  output logic [ANGLE_W-1:0] ld_angle,
  output logic               ld_buf,
  input  logic               ld_done,
  input  logic               hs_next_angle,
  output logic               hs_next_angle_ack,
  output logic [ANGLE_W-1:0] hs_angle,
  output logic               fr_rd_buf,
  output logic               busy,
`ifdef NABP_SEQ_PERF_EN
  output logic [STALL_W-1:0] stall_cycles,
`endif
  output logic               done
);

  seq_state_t         state, next_state;
  logic               start_accept;
  logic               fill_done;
  logic               last_issue;
  logic               kick_target;
  logic               first_kick;
  logic               pend_buf;
  logic [CNT_W-1:0]   num_angles;
  logic [CNT_W-1:0]   issued_cnt;
  logic [ANGLE_W-1:0] load_angle;
  logic [ANGLE_W-1:0] pend_angle;

  nabp_angle_accu #(
    .ANGLE_W  (ANGLE_W),
    .ANGLE_MAX(ANGLE_MAX)
  ) u_accu (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (start_accept),
    .load_angle(cfg_angle_start),
    .load_step (cfg_angle_step),
    .advance   (fill_done),
    .angle     (load_angle)
  );

  // The first fill of a sweep always targets fr0; later fills go to the buffer not being read.
  assign kick_target = first_kick ? 1'b0 : ~fr_rd_buf;
  assign last_issue  = (issued_cnt + CNT_W'(1)) == num_angles;

  assign ld_angle = ld_kick ? load_angle : '0;
  assign ld_buf   = ld_kick & kick_target;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state        = state;
    start_accept      = 1'b0;
    fill_done         = 1'b0;
    ld_kick           = 1'b0;
    hs_next_angle_ack = 1'b0;
    done              = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          next_state   = (cfg_num_angles != '0) ? S_KICK : S_DONE;
        end
      end
      S_KICK: begin
        ld_kick    = 1'b1;
        next_state = S_LOADING;
      end
      S_LOADING: begin
        if (ld_done) begin
          fill_done  = 1'b1;
          next_state = S_PEND;
        end
      end
      S_PEND: begin
        // Grant is Mealy so swap control sees it in the same cycle as its request.
        if (hs_next_angle) begin
          hs_next_angle_ack = 1'b1;
          next_state        = last_issue ? S_DRAIN : S_KICK;
        end
      end
      S_DRAIN: begin
        if (hs_next_angle) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_angles <= '0;
      issued_cnt <= '0;
      first_kick <= 1'b0;
      pend_buf   <= 1'b0;
      pend_angle <= '0;
      hs_angle   <= '0;
      fr_rd_buf  <= 1'b0;
    end else begin
      if (start_accept) begin
        num_angles <= cfg_num_angles;
        issued_cnt <= '0;
        first_kick <= 1'b1;
      end
      if (ld_kick) begin
        pend_buf   <= kick_target;
        first_kick <= 1'b0;
      end
      if (fill_done) begin
        pend_angle <= load_angle;
      end
      if (hs_next_angle_ack) begin
        hs_angle   <= pend_angle;
        fr_rd_buf  <= pend_buf;
        issued_cnt <= issued_cnt + CNT_W'(1);
      end
    end
  end

`ifdef NABP_SEQ_PERF_EN
  logic stalled;

  // A request seen while the next angle is still being kicked or loaded means the loader is late.
  assign stalled = hs_next_angle && ((state == S_KICK) || (state == S_LOADING));

  always_ff @(posedge clk) begin
    if (!reset_n || start_accept) begin
      stall_cycles <= '0;
    end else if (stalled && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Randomized self-checking bench for nabp_angle_sequencer against a sweep-level angle/buffer model.
module tb_nabp_angle_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] cfg_angle_start;
  logic [7:0] cfg_angle_step;
  logic [7:0] cfg_num_angles;
  logic       ld_kick;
  logic [7:0] ld_angle;
  logic       ld_buf;
  logic       ld_done;
  logic       ld_done_ld = 1'b0;
  logic       ld_done_stray = 1'b0;
  logic       hs_next_angle;
  logic       hs_next_angle_ack;
  logic [7:0] hs_angle;
  logic       fr_rd_buf;
  logic       busy;
  logic       done;
`ifdef NABP_SEQ_PERF_EN
  logic [15:0] stall_cycles;
`endif

  assign ld_done = ld_done_ld | ld_done_stray;

  always #5 clk = ~clk;

  nabp_angle_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .cfg_angle_start  (cfg_angle_start),
    .cfg_angle_step   (cfg_angle_step),
    .cfg_num_angles   (cfg_num_angles),
    .ld_kick          (ld_kick),
    .ld_angle         (ld_angle),
    .ld_buf           (ld_buf),
    .ld_done          (ld_done),
    .hs_next_angle    (hs_next_angle),
    .hs_next_angle_ack(hs_next_angle_ack),
    .hs_angle         (hs_angle),
    .fr_rd_buf        (fr_rd_buf),
    .busy             (busy),
`ifdef NABP_SEQ_PERF_EN
    .stall_cycles     (stall_cycles),
`endif
    .done             (done)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Expectations written by the stimulus side
  int exp_angles [256];
  int exp_n     = 0;
  int sweep_id  = 0;
  int ld_delay  = 1;
  bit hold_mode = 1'b0;
  bit mon_en    = 1'b0;
  bit loader_en = 1'b1;

  // State owned by the monitor
  int cyc          = 0;
  int seen_id      = 0;
  int kick_idx     = 0;
  int ack_idx      = 0;
  int fill_cnt     = 0;
  int busy_cnt     = 0;
  int start_cyc    = -1;
  int done_cyc     = -1;
  int last_ack_cyc = -1;
  int stall_model  = 0;
  bit start_pending = 1'b0;
  bit in_loading    = 1'b0;
  bit prev_fill     = 1'b0;

  // Owned by the loader model
  bit fill_active = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Loader model: answers each kick with one ld_done pulse after ld_delay cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (ld_kick && loader_en) begin
        fill_active = 1'b1;
        repeat (ld_delay) @(posedge clk);
        #1 ld_done_ld = 1'b1;
        @(posedge clk);
        #1 ld_done_ld = 1'b0;
        fill_active = 1'b0;
      end
    end
  end

  // Monitor: checks every observable event of a sweep against the expected angle list.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (seen_id != sweep_id) begin
        seen_id       = sweep_id;
        kick_idx      = 0;
        ack_idx       = 0;
        fill_cnt      = 0;
        busy_cnt      = 0;
        start_cyc     = -1;
        done_cyc      = -1;
        last_ack_cyc  = -1;
        stall_model   = 0;
        start_pending = 1'b1;
        in_loading    = 1'b0;
        prev_fill     = 1'b0;
      end
      if (mon_en) begin
        if (start && !busy && start_pending) begin
          start_cyc     = cyc;
          start_pending = 1'b0;
          stall_model   = 0;
        end
        if (!start_pending && busy) busy_cnt++;
        if (hs_next_angle && (ld_kick || in_loading) && stall_model < 65535) stall_model++;
        if (ack_idx > 0 && ack_idx <= exp_n) begin
          checkOutput("hs_angle", hs_angle, exp_angles[ack_idx-1]);
          checkOutput("fr_rd_buf", fr_rd_buf, (ack_idx - 1) % 2);
        end
        if (ld_kick) begin
          if (kick_idx < exp_n) begin
            checkOutput("ld_angle", ld_angle, exp_angles[kick_idx]);
            checkOutput("ld_buf", ld_buf, kick_idx % 2);
          end else begin
            checkOutput("kick_extra", kick_idx, exp_n);
          end
          kick_idx++;
        end
        if (hold_mode && prev_fill) checkOutput("ack_latency", hs_next_angle_ack, 1);
        if (hs_next_angle_ack) begin
          checkOutput("ack_req", hs_next_angle, 1);
          checkOutput("ack_loaded", ack_idx < fill_cnt, 1);
          if (ack_idx >= exp_n) checkOutput("ack_extra", ack_idx, exp_n);
          ack_idx++;
          last_ack_cyc = cyc;
        end
        if (done) begin
          done_cyc = cyc;
          checkOutput("done_acks", ack_idx, exp_n);
        end
        prev_fill = in_loading && ld_done;
        if (prev_fill) begin
          fill_cnt++;
          in_loading = 1'b0;
        end
        if (ld_kick) in_loading = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input int a0, input int step, input int n, input int delay,
                               input bit hold, input bit inject);
    bit seen_done;
    bit may_stray;
    bit may_start;
    seen_done = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 256; k++) exp_angles[k] = (a0 + k * step) % 180;
    exp_n           = n;
    hold_mode       = hold;
    ld_delay        = delay;
    sweep_id        = sweep_id + 1;
    cfg_angle_start = 8'(a0);
    cfg_angle_step  = 8'(step);
    cfg_num_angles  = 8'(n);
    start           = 1'b1;
    hs_next_angle   = hold;
    @(posedge clk);
    #1;
    start           = 1'b0;
    cfg_angle_start = 8'($urandom_range(0, 179));
    cfg_angle_step  = 8'($urandom_range(0, 179));
    cfg_num_angles  = 8'($urandom_range(0, 255));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      may_stray = inject && !ld_kick && !fill_active;
      may_start = inject;
      @(posedge clk);
      #1;
      hs_next_angle = hold ? 1'b1 : ($urandom_range(0, 1) == 1);
      ld_done_stray = may_stray && ($urandom_range(0, 3) == 0);
      start         = may_start && ($urandom_range(0, 7) == 0);
    end
    @(posedge clk);
    #1;
    hs_next_angle = 1'b0;
    ld_done_stray = 1'b0;
    start         = 1'b0;
    @(negedge clk);
    checkOutput("done_seen", seen_done, 1);
    checkOutput("kick_count", kick_idx, n);
    checkOutput("ack_count", ack_idx, n);
    checkOutput("busy_span", busy_cnt, done_cyc - start_cyc);
    if (n == 0) checkOutput("empty_done_lat", done_cyc - start_cyc, 1);
    else if (hold) checkOutput("drain_done_lat", done_cyc - last_ack_cyc, 2);
    checkOutput("idle_busy", busy, 0);
`ifdef NABP_SEQ_PERF_EN
    checkOutput("stall_cycles", stall_cycles, stall_model);
`endif
  endtask

  task automatic resetMidSweep();
    mon_en    = 1'b0;
    loader_en = 1'b0;
    @(posedge clk);
    #1;
    sweep_id        = sweep_id + 1;
    cfg_angle_start = 8'd0;
    cfg_angle_step  = 8'd45;
    cfg_num_angles  = 8'd4;
    start           = 1'b1;
    hs_next_angle   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_kick", ld_kick, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n       = 1'b1;
    ld_done_stray = 1'b1;
    @(posedge clk);
    #1;
    ld_done_stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_ack", hs_next_angle_ack, 0);
      checkOutput("rst_kick_idle", ld_kick, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_hs_angle", hs_angle, 0);
      checkOutput("rst_fr_rd_buf", fr_rd_buf, 0);
`ifdef NABP_SEQ_PERF_EN
      checkOutput("rst_stall", stall_cycles, 0);
`endif
    end
    hs_next_angle = 1'b0;
    loader_en     = 1'b1;
    mon_en        = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    cfg_angle_start = 8'd0;
    cfg_angle_step  = 8'd0;
    cfg_num_angles  = 8'd0;
    hs_next_angle   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_kick", ld_kick, 0);
    checkOutput("reset_ld_angle", ld_angle, 0);
    checkOutput("reset_ld_buf", ld_buf, 0);
    checkOutput("reset_ack", hs_next_angle_ack, 0);
    checkOutput("reset_hs_angle", hs_angle, 0);
    checkOutput("reset_fr_rd_buf", fr_rd_buf, 0);
`ifdef NABP_SEQ_PERF_EN
    checkOutput("reset_stall", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    $display("[TB] basic sweep 0/45/4");
    applyStimulus(0, 45, 4, 5, 1'b1, 1'b0);
    $display("[TB] wrapping sweep 170/20/3");
    applyStimulus(170, 20, 3, 3, 1'b1, 1'b0);
    $display("[TB] slow loader with held request");
    applyStimulus(10, 7, 2, 40, 1'b1, 1'b0);
    $display("[TB] empty sweep");
    applyStimulus(90, 30, 0, 3, 1'b1, 1'b0);
    $display("[TB] reset while loading");
    resetMidSweep();
    applyStimulus(0, 45, 4, 5, 1'b1, 1'b0);
    $display("[TB] stray start and ld_done");
    applyStimulus(20, 50, 5, 4, 1'b0, 1'b1);
    $display("[TB] random sweeps");
    for (int i = 0; i < 6; i++) begin
      bit h;
      h = ($urandom_range(0, 1) == 1);
      applyStimulus($urandom_range(0, 179), $urandom_range(0, 179), $urandom_range(1, 12),
                    $urandom_range(1, 8), h, !h);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
